// File: rtl/operand_fetch.sv
// Operand fetch: reads register file sources, bypasses same-cycle writeback, and holds
// a 32-entry busy scoreboard that stalls RAW/WAW hazards before registering operands.
module operand_fetch #(
    parameter int WORD_SIZE = 32,
    parameter int CTRL_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_rs1,
    input  logic [4:0]           in_rs2,
    input  logic [4:0]           in_rd,
    input  logic                 in_uses_rs1,
    input  logic                 in_uses_rs2,
    input  logic                 in_writes_rd,
    input  logic [CTRL_W-1:0]    in_ctrl,
    output logic [4:0]           rf_a1,
    output logic [4:0]           rf_a2,
    input  logic [WORD_SIZE-1:0] rf_a_data,
    input  logic [WORD_SIZE-1:0] rf_b_data,
    input  logic                 wb_valid,
    input  logic [4:0]           wb_rd,
    input  logic [WORD_SIZE-1:0] wb_data,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WORD_SIZE-1:0] out_rs1_val,
    output logic [WORD_SIZE-1:0] out_rs2_val,
    output logic [4:0]           out_rd,
    output logic                 out_writes_rd,
    output logic [CTRL_W-1:0]    out_ctrl
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // a producer holding valid keeps its payload stable until that transfer.

    logic [31:0]          busy;
    logic [31:0]          busy_nxt;
    logic                 hit_rs1;
    logic                 hit_rs2;
    logic                 hit_rd;
    logic                 hazard_rs1;
    logic                 hazard_rs2;
    logic                 hazard_rd;
    logic                 accept;
    logic [WORD_SIZE-1:0] op1;
    logic [WORD_SIZE-1:0] op2;

    assign rf_a1 = in_rs1;
    assign rf_a2 = in_rs2;

    assign hit_rs1 = wb_valid && (wb_rd == in_rs1) && (in_rs1 != 5'd0);
    assign hit_rs2 = wb_valid && (wb_rd == in_rs2) && (in_rs2 != 5'd0);
    assign hit_rd  = wb_valid && (wb_rd == in_rd)  && (in_rd  != 5'd0);

    // A writeback landing this cycle resolves the hazard, so it does not stall.
    assign hazard_rs1 = in_uses_rs1  && (in_rs1 != 5'd0) && busy[in_rs1] && !hit_rs1;
    assign hazard_rs2 = in_uses_rs2  && (in_rs2 != 5'd0) && busy[in_rs2] && !hit_rs2;
    assign hazard_rd  = in_writes_rd && (in_rd  != 5'd0) && busy[in_rd]  && !hit_rd;

    assign in_ready = !flush && (!out_valid || out_ready)
                      && !hazard_rs1 && !hazard_rs2 && !hazard_rd;
    assign accept   = in_valid && in_ready;

    always_comb begin
        op1 = rf_a_data;
        op2 = rf_b_data;
        if (in_rs1 == 5'd0)  op1 = '0;
        else if (hit_rs1)    op1 = wb_data;
        if (in_rs2 == 5'd0)  op2 = '0;
        else if (hit_rs2)    op2 = wb_data;
    end

    // Clears first, then the accept's set, so a same-register set/clear leaves the bit set.
    always_comb begin
        busy_nxt = busy;
        if (wb_valid && (wb_rd != 5'd0))
            busy_nxt[wb_rd] = 1'b0;
        if (flush && out_valid && out_writes_rd && (out_rd != 5'd0))
            busy_nxt[out_rd] = 1'b0;
        if (accept && in_writes_rd && (in_rd != 5'd0))
            busy_nxt[in_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid     <= 1'b0;
            out_rs1_val   <= '0;
            out_rs2_val   <= '0;
            out_rd        <= '0;
            out_writes_rd <= 1'b0;
            out_ctrl      <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid     <= 1'b1;
            out_rs1_val   <= op1;
            out_rs2_val   <= op2;
            out_rd        <= in_rd;
            out_writes_rd <= in_writes_rd;
            out_ctrl      <= in_ctrl;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: a vector table for single-cycle issue behaviour and
// hand-written sequences for backpressure, flush and asynchronous reset.
module tb_operand_fetch;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_uses_rs1, in_uses_rs2, in_writes_rd;
    logic [15:0] in_ctrl;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_a_data, rf_b_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_rs1_val, out_rs2_val;
    logic [4:0]  out_rd;
    logic        out_writes_rd;
    logic [15:0] out_ctrl;

    int total = 0;
    int bad   = 0;

    operand_fetch #(.WORD_SIZE(32), .CTRL_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_uses_rs1(in_uses_rs1), .in_uses_rs2(in_uses_rs2), .in_writes_rd(in_writes_rd),
        .in_ctrl(in_ctrl),
        .rf_a1(rf_a1), .rf_a2(rf_a2), .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_rs1_val(out_rs1_val), .out_rs2_val(out_rs2_val),
        .out_rd(out_rd), .out_writes_rd(out_writes_rd), .out_ctrl(out_ctrl)
    );

    // clock/reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        logic        u1, u2, w;
        logic [15:0] ctrl;
        logic [31:0] a, b;
        logic        wbv;
        logic [4:0]  wbrd;
        logic [31:0] wbd;
        logic        exp_rdy;
        logic [31:0] e1, e2;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_uses_rs1 = 0; in_uses_rs2 = 0; in_writes_rd = 0; in_ctrl = 0;
        rf_a_data = 0; rf_b_data = 0;
        wb_valid = 0; wb_rd = 0; wb_data = 0;
        flush = 0;
    endtask

    task automatic drive_instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                               input logic u1, input logic u2, input logic w,
                               input logic [15:0] ctrl, input logic [31:0] a, input logic [31:0] b);
        in_valid = 1; in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
        in_uses_rs1 = u1; in_uses_rs2 = u2; in_writes_rd = w; in_ctrl = ctrl;
        rf_a_data = a; rf_b_data = b;
    endtask

    // Observes busy[r] through the RAW interlock: with no instruction offered and the
    // output free, in_ready is exactly !busy[r].
    task automatic probe_busy(input string name, input logic [4:0] r, input logic exp_busy);
        idle_inputs();
        out_ready = 1;
        in_uses_rs1 = 1; in_rs1 = r;
        #1;
        chk(name, {63'd0, in_ready}, {63'd0, !exp_busy});
        in_uses_rs1 = 0; in_rs1 = 0;
    endtask

    initial begin
        // Vector table: applied back to back with out_ready=1, busy state carries over.
        //           rs1    rs2    rd     u1 u2 w  ctrl     a             b             wbv wbrd   wbd           rdy e1            e2
        vecs[0] = '{5'd1, 5'd2, 5'd3, 1, 1, 1, 16'h0001, 32'h11,       32'h22,       0, 5'd0,  32'h0,        1, 32'h11,       32'h22};
        vecs[1] = '{5'd3, 5'd0, 5'd4, 1, 0, 1, 16'h0002, 32'h33,       32'h44,       0, 5'd0,  32'h0,        0, 32'h0,        32'h0};
        vecs[2] = '{5'd3, 5'd0, 5'd4, 1, 0, 1, 16'h0003, 32'h33,       32'h44,       1, 5'd3,  32'hDEAD,     1, 32'hDEAD,     32'h0};
        vecs[3] = '{5'd0, 5'd0, 5'd0, 1, 1, 1, 16'h0004, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 5'd0,  32'h55,       1, 32'h0,        32'h0};
        vecs[4] = '{5'd4, 5'd6, 5'd5, 0, 1, 1, 16'h0005, 32'h99,       32'h66,       0, 5'd0,  32'h0,        1, 32'h99,       32'h66};
        vecs[5] = '{5'd1, 5'd2, 5'd5, 1, 1, 1, 16'h0006, 32'h11,       32'h22,       0, 5'd0,  32'h0,        0, 32'h0,        32'h0};
        vecs[6] = '{5'd5, 5'd2, 5'd5, 1, 1, 1, 16'h0007, 32'h77,       32'h22,       1, 5'd5,  32'h123,      1, 32'h123,      32'h22};
        vecs[7] = '{5'd1, 5'd4, 5'd0, 1, 1, 0, 16'h0008, 32'h7,        32'h8,        1, 5'd4,  32'hBEEF,     1, 32'h7,        32'hBEEF};
        vecs[8] = '{5'd1, 5'd5, 5'd0, 1, 1, 0, 16'h0009, 32'h1,        32'h2,        0, 5'd0,  32'h0,        0, 32'h0,        32'h0};
        vecs[9] = '{5'd1, 5'd2, 5'd5, 1, 1, 1, 16'h000A, 32'h1,        32'h2,        1, 5'd9,  32'h9,        0, 32'h0,        32'h0};

        idle_inputs();
        out_ready = 1;
        rst_n = 0;
        step();
        step();
        chk("reset_out_valid", {63'd0, out_valid}, 64'd0);
        chk("reset_out_rs1", {32'd0, out_rs1_val}, 64'd0);
        chk("reset_out_rd", {59'd0, out_rd}, 64'd0);
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1;
        step();

        for (int i = 0; i < 10; i++) begin
            drive_instr(vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].u1, vecs[i].u2,
                        vecs[i].w, vecs[i].ctrl, vecs[i].a, vecs[i].b);
            wb_valid = vecs[i].wbv; wb_rd = vecs[i].wbrd; wb_data = vecs[i].wbd;
            #1;
            chk($sformatf("v%0d_in_ready", i), {63'd0, in_ready}, {63'd0, vecs[i].exp_rdy});
            chk($sformatf("v%0d_rf_a1", i), {59'd0, rf_a1}, {59'd0, vecs[i].rs1});
            step();
            chk($sformatf("v%0d_out_valid", i), {63'd0, out_valid}, {63'd0, vecs[i].exp_rdy});
            if (vecs[i].exp_rdy) begin
                chk($sformatf("v%0d_rs1_val", i), {32'd0, out_rs1_val}, {32'd0, vecs[i].e1});
                chk($sformatf("v%0d_rs2_val", i), {32'd0, out_rs2_val}, {32'd0, vecs[i].e2});
                chk($sformatf("v%0d_rd", i), {59'd0, out_rd}, {59'd0, vecs[i].rd});
                chk($sformatf("v%0d_wr", i), {63'd0, out_writes_rd}, {63'd0, vecs[i].w});
                chk($sformatf("v%0d_ctrl", i), {48'd0, out_ctrl}, {48'd0, vecs[i].ctrl});
            end
        end
        idle_inputs();
        probe_busy("busy3_clear", 5'd3, 0);
        probe_busy("busy4_clear", 5'd4, 0);
        probe_busy("busy5_set", 5'd5, 1);

        // Backpressure: hold X for 3 cycles, then fire X and accept Y together.
        drive_instr(5'd1, 5'd2, 5'd8, 1, 1, 1, 16'hAAAA, 32'hA1, 32'hB2);
        out_ready = 1;
        step();
        chk("bp_x_valid", {63'd0, out_valid}, 64'd1);
        drive_instr(5'd1, 5'd2, 5'd7, 1, 1, 1, 16'h5555, 32'hC1, 32'hD2);
        out_ready = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_in_ready", c), {63'd0, in_ready}, 64'd0);
            step();
            chk($sformatf("bp%0d_valid", c), {63'd0, out_valid}, 64'd1);
            chk($sformatf("bp%0d_rs1", c), {32'd0, out_rs1_val}, 64'hA1);
            chk($sformatf("bp%0d_ctrl", c), {48'd0, out_ctrl}, 64'hAAAA);
        end
        out_ready = 1;
        #1;
        chk("bp_fire_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        chk("bp_y_valid", {63'd0, out_valid}, 64'd1);
        chk("bp_y_rs1", {32'd0, out_rs1_val}, 64'hC1);
        chk("bp_y_rs2", {32'd0, out_rs2_val}, 64'hD2);
        chk("bp_y_rd", {59'd0, out_rd}, 64'd7);

        // Flush the held rd=7 instruction while a writeback to r8 lands.
        idle_inputs();
        out_ready = 1;
        flush = 1;
        wb_valid = 1; wb_rd = 5'd8; wb_data = 32'h8;
        in_valid = 1;
        #1;
        chk("flush_in_ready", {63'd0, in_ready}, 64'd0);
        step();
        chk("flush_out_valid", {63'd0, out_valid}, 64'd0);
        probe_busy("flush_busy7", 5'd7, 0);
        probe_busy("flush_busy8", 5'd8, 0);
        probe_busy("flush_busy5", 5'd5, 1);

        // Asynchronous reset mid-stall with a held instruction.
        drive_instr(5'd1, 5'd2, 5'd10, 1, 1, 1, 16'h1234, 32'hE1, 32'hE2);
        out_ready = 1;
        step();
        chk("rst_pre_valid", {63'd0, out_valid}, 64'd1);
        out_ready = 0;
        drive_instr(5'd5, 5'd0, 5'd0, 1, 0, 0, 16'h0, 32'h0, 32'h0);
        #1;
        chk("rst_pre_stall", {63'd0, in_ready}, 64'd0);
        #1;
        rst_n = 0;
        #1;
        chk("rst_mid_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_mid_rs1", {32'd0, out_rs1_val}, 64'd0);
        chk("rst_mid_ctrl", {48'd0, out_ctrl}, 64'd0);
        chk("rst_mid_in_ready", {63'd0, in_ready}, 64'd1);
        rst_n = 1;
        step();
        probe_busy("rst_busy10", 5'd10, 0);
        probe_busy("rst_busy5", 5'd5, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
